// File: rtl/mem_arbiter.sv
// CPU / debug-port arbiter in front of a single-port synchronous-read memory.
// Optional: define MEM_ARB_LOCK_EN for cpu_lock/dbg_lock ownership retention.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic                  cpu_lock,
  input  logic                  dbg_lock,
`endif
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t                state;
  logic                  own_dbg;
  logic [7:0]            dbg_wait;
  logic [DATA_WIDTH-1:0] cpu_hold;
  logic [DATA_WIDTH-1:0] dbg_hold;
  logic                  starve;
  logic                  pick_dbg;
`ifdef MEM_ARB_LOCK_EN
  logic                  own_vld;
`endif

  assign starve = (dbg_wait == LIMIT);

  always_comb begin
    pick_dbg = dbg_req && (!cpu_req || starve);
`ifdef MEM_ARB_LOCK_EN
    if (own_vld && own_dbg && dbg_lock && dbg_req)
      pick_dbg = 1'b1;
    else if (own_vld && !own_dbg && cpu_lock && cpu_req)
      pick_dbg = 1'b0;
`endif
  end

  // Memory data arrives during RESP; pass it through, then hold it.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_hold;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state      <= IDLE;
      own_dbg    <= 1'b0;
      dbg_wait   <= '0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= '0;
      dbg_hold   <= '0;
`ifdef MEM_ARB_LOCK_EN
      own_vld    <= 1'b0;
`endif
    end else begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_we     <= 1'b0;

      if (!dbg_req || dbg_gnt)
        dbg_wait <= '0;
      else if (dbg_wait != LIMIT)
        dbg_wait <= dbg_wait + 8'd1;

      unique case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            own_dbg   <= pick_dbg;
            mem_addr  <= pick_dbg ? dbg_addr : cpu_addr;
            mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
            mem_we    <= pick_dbg ? dbg_we : cpu_we;
            cpu_gnt   <= !pick_dbg;
            dbg_gnt   <= pick_dbg;
            state     <= ACCESS;
`ifdef MEM_ARB_LOCK_EN
            own_vld   <= 1'b1;
`endif
          end
        end
        ACCESS: begin
          // mem_we is high in ACCESS exactly for writes
          if (mem_we) begin
            state <= IDLE;
          end else begin
            cpu_rvalid <= !own_dbg;
            dbg_rvalid <= own_dbg;
            state      <= RESP;
          end
        end
        RESP: begin
          if (own_dbg)
            dbg_hold <= mem_rdata;
          else
            cpu_hold <= mem_rdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level model with a shadow memory.
module tb_mem_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_LOCK_EN
  logic          cpu_lock, dbg_lock;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
`ifdef MEM_ARB_LOCK_EN
    .cpu_lock  (cpu_lock),
    .dbg_lock  (dbg_lock),
`endif
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // synchronous-read memory
  logic [DW-1:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic do_reset();
    arst_n = 0;
    idle_inputs();
    tick();
    tick();
    arst_n = 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_gnt"}, cpu_gnt, 0);
    chk({tag, "_dbg_gnt"}, dbg_gnt, 0);
    chk({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
    chk({tag, "_dbg_rvalid"}, dbg_rvalid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
  endtask

  typedef struct {
    bit          dbg;
    bit          we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  // single transfer from IDLE: gnt at N+1, rvalid at N+2
  task automatic run_vec(input vec_t v);
    if (v.dbg) begin
      dbg_req = 1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    tick();
    chk("vec_gnt", v.dbg ? dbg_gnt : cpu_gnt, 1);
    chk("vec_other_gnt", v.dbg ? cpu_gnt : dbg_gnt, 0);
    chk("vec_mem_we", mem_we, v.we);
    chk("vec_mem_addr", mem_addr, v.addr);
    if (v.we) chk("vec_mem_wdata", mem_wdata, v.wdata);
    cpu_req = 0;
    dbg_req = 0;
    tick();
    chk("vec_gnt_pulse", {cpu_gnt, dbg_gnt}, 0);
    chk("vec_we_pulse", mem_we, 0);
    chk("vec_addr_hold", mem_addr, v.addr);
    if (!v.we) begin
      chk("vec_rvalid", v.dbg ? dbg_rvalid : cpu_rvalid, 1);
      chk("vec_other_rvalid", v.dbg ? cpu_rvalid : dbg_rvalid, 0);
      chk("vec_rdata", v.dbg ? dbg_rdata : cpu_rdata, v.exp_rdata);
      tick();
      chk("vec_rvalid_pulse", {cpu_rvalid, dbg_rvalid}, 0);
      chk("vec_rdata_hold", v.dbg ? dbg_rdata : cpu_rdata, v.exp_rdata);
    end else begin
      chk("vec_wr_no_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
    end
  endtask

  // transaction-level reference model state
  logic [7:0] shadow [256] = '{default: 8'h00};
  int         busy, rd_cnt, m_wait;
  bit         rd_dbg, prev_dg;
  logic [7:0] rd_val, e_addr, e_wdata, e_crd, e_drd;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    bit   c_pend, d_pend;
    bit   p_creq, p_cwe, p_dreq, p_dwe, starve, wd;
    logic [7:0] p_caddr, p_cwd, p_daddr, p_dwd;
    bit   e_cg, e_dg, e_we, e_cv, e_dv;
    int   cg_at[$];

`ifdef MEM_ARB_LOCK_EN
    cpu_lock = 0;
    dbg_lock = 0;
`endif
    do_reset();
    chk_all_zero("reset");

    vecs[0] = '{0, 1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{0, 0, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1, 1, 8'h20, 8'h3C, 8'h00};
    vecs[3] = '{1, 0, 8'h20, 8'h00, 8'h3C};
    vecs[4] = '{0, 1, 8'hFF, 8'h00, 8'h00};
    vecs[5] = '{0, 0, 8'hFF, 8'h5A, 8'h00};
    vecs[6] = '{1, 0, 8'h10, 8'h00, 8'hA5};
    vecs[7] = '{0, 1, 8'h00, 8'hFF, 8'h00};
    vecs[8] = '{1, 0, 8'h00, 8'h00, 8'hFF};
    foreach (vecs[i]) run_vec(vecs[i]);

    // simultaneous requests, no starvation pending: CPU first
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 8'h11;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h31; dbg_wdata = 8'h22;
    tick();
    chk("both_cpu_first", {cpu_gnt, dbg_gnt}, 2'b10);
    cpu_req = 0;
    tick();
    chk("both_gap", {cpu_gnt, dbg_gnt}, 2'b00);
    tick();
    chk("both_dbg_next", {cpu_gnt, dbg_gnt}, 2'b01);
    chk("both_dbg_addr", mem_addr, 8'h31);
    dbg_req = 0;
    tick();
    tick();

    // both held: CPU wins twice, starvation hands one slot to debug
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'h01;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h41; dbg_wdata = 8'h02;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("starve_cpu_gnt_e%0d", e), cpu_gnt,
          (e == 1 || e == 3 || e == 7));
      chk($sformatf("starve_dbg_gnt_e%0d", e), dbg_gnt, (e == 5));
    end
    idle_inputs();
    tick();
    tick();

    // reset during ACCESS (rst_at=2) and during RESP (rst_at=3) of a read
    for (int rst_at = 2; rst_at <= 3; rst_at++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      tick();
      chk("rst_rd_gnt", cpu_gnt, 1);
      cpu_req = 0;
      if (rst_at == 3) begin
        tick();
        chk("rst_rd_rvalid_before", cpu_rvalid, 1);
      end
      arst_n = 0;
      tick();
      chk_all_zero($sformatf("rst_at%0d", rst_at));
      arst_n = 1;
      tick();
      chk("rst_no_rvalid_after", {cpu_rvalid, dbg_rvalid}, 0);
      run_vec('{0, 0, 8'h10, 8'h00, 8'hA5});
    end

    // write in flight when reset hits: mem_we drops at the reset edge
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h33; cpu_wdata = 8'h77;
    tick();
    chk("rst_wr_we", mem_we, 1);
    cpu_req = 0;
    arst_n = 0;
    tick();
    chk("rst_wr_we_low", mem_we, 0);
    arst_n = 1;
    tick();

`ifdef MEM_ARB_LOCK_EN
    begin
      int dcnt;
      int at_cpu;
      dbg_lock = 1;
      dbg_req = 1; dbg_we = 1; dbg_addr = 8'h50; dbg_wdata = 8'h50;
      tick();
      chk("lock_prime_gnt", dbg_gnt, 1);
      dbg_addr = 8'h51;
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h60; cpu_wdata = 8'h66;
      dcnt = 0;
      at_cpu = 99;
      for (int e = 0; e < 20 && at_cpu == 99; e++) begin
        tick();
        if (cpu_gnt) at_cpu = dcnt;
        if (dbg_gnt) begin
          dcnt++;
          dbg_addr = dbg_addr + 8'd1;
          if (dcnt == 3) dbg_req = 0;
        end
      end
      chk("lock_dbg_before_cpu", at_cpu, 3);
      dbg_lock = 0;
      idle_inputs();
      tick();
      tick();
    end
`endif

    // randomized run against the transaction-level model
    do_reset();
    busy = 0; rd_cnt = 0; m_wait = 0; prev_dg = 0;
    e_addr = 0; e_wdata = 0; e_crd = 0; e_drd = 0;
    c_pend = 0; d_pend = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!c_pend && $urandom_range(0, 9) < 7) begin
        c_pend = 1;
        cpu_we = 1'($urandom);
        cpu_addr = 8'h80 | 8'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end
      if (!d_pend && $urandom_range(0, 9) < 4) begin
        d_pend = 1;
        dbg_we = 1'($urandom);
        dbg_addr = 8'h80 | 8'($urandom_range(0, 15));
        dbg_wdata = 8'($urandom);
      end
      cpu_req = c_pend;
      dbg_req = d_pend;
      p_creq = cpu_req; p_cwe = cpu_we; p_caddr = cpu_addr; p_cwd = cpu_wdata;
      p_dreq = dbg_req; p_dwe = dbg_we; p_daddr = dbg_addr; p_dwd = dbg_wdata;
      tick();

      e_cg = 0; e_dg = 0; e_we = 0; e_cv = 0; e_dv = 0;
      if (rd_cnt == 1) begin
        if (rd_dbg) begin e_dv = 1; e_drd = rd_val; end
        else begin e_cv = 1; e_crd = rd_val; end
        rd_cnt = 0;
      end
      starve = (m_wait == LIMIT);
      if (busy == 0) begin
        if (p_creq || p_dreq) begin
          wd = p_dreq && (!p_creq || starve);
          e_cg = !wd;
          e_dg = wd;
          e_addr = wd ? p_daddr : p_caddr;
          e_wdata = wd ? p_dwd : p_cwd;
          e_we = wd ? p_dwe : p_cwe;
          if (e_we) begin
            shadow[e_addr] = e_wdata;
            busy = 1;
          end else begin
            rd_cnt = 1;
            rd_dbg = wd;
            rd_val = shadow[e_addr];
            busy = 2;
          end
        end
      end else begin
        busy--;
      end
      if (!p_dreq || prev_dg) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
      prev_dg = e_dg;

      chk("rnd_cpu_gnt", cpu_gnt, e_cg);
      chk("rnd_dbg_gnt", dbg_gnt, e_dg);
      chk("rnd_mem_we", mem_we, e_we);
      chk("rnd_mem_addr", mem_addr, e_addr);
      chk("rnd_mem_wdata", mem_wdata, e_wdata);
      chk("rnd_cpu_rvalid", cpu_rvalid, e_cv);
      chk("rnd_dbg_rvalid", dbg_rvalid, e_dv);
      chk("rnd_cpu_rdata", cpu_rdata, e_crd);
      chk("rnd_dbg_rdata", dbg_rdata, e_drd);

      if (cpu_gnt) c_pend = 0;
      if (dbg_gnt) d_pend = 0;
      if (cpu_gnt) cg_at.push_back(cyc);
    end
    chk("rnd_cpu_activity", (cg_at.size() > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
